// File: rtl/serial_subtractor_4bit.sv
// rtl/serial_subtractor_4bit.sv - bit-serial two's-complement subtractor, Diff = A - B - Bin, LSB first
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   busy_nxt, done_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;

    logic d;
    logic br_nxt;
    logic last;
    logic accept;

    assign d      = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign last   = (cnt == LAST);
    assign accept = (state == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so outputs come straight from flops
    always_comb begin
        busy_nxt = (state_nxt == S_SHIFT);
        done_nxt = (state_nxt == S_DONE);
    end

    // a_sr doubles as the working register: each difference bit enters at the MSB
    // as the consumed minuend bit leaves at the LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            br       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
            Diff     <= '0;
            Bout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            cnt   <= '0;
        end else if (state == S_SHIFT) begin
            a_sr <= {d, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
                Diff     <= {d, a_sr[WIDTH-1:1]};
                Bout     <= br_nxt;
                Overflow <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// tb/tb_serial_subtractor_4bit.sv - scoreboard bench for serial_subtractor_4bit against an arithmetic model
module tb_serial_subtractor_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       Bin = 1'b0;
    logic       busy, done, Bout, Overflow;
    logic [3:0] Diff;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pushed = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0] d;
        logic       bo;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t q[$];

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Overflow(Overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic bin, input int c);
        exp_t e;
        int u, s;
        u = int'(a) - int'(b) - int'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.d   = u[3:0];
        e.bo  = (u < 0);
        e.ov  = (s < -8) || (s > 7);
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("diff", Diff, e.d);
                chk("bout", Bout, e.bo);
                chk("overflow", Overflow, e.ov);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic wait_idle(output bit ok);
        int guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = (guard < 50);
        if (!ok) chk("idle_timeout", guard, 0);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin);
        bit ok;
        wait_idle(ok);
        if (ok) begin
            A = a; B = b; Bin = bin; start = 1'b1;
            q.push_back(model(a, b, bin, cyc + 1 + 4));
            pushed++;
            @(posedge clk);
            #1;
            start = 1'b0;
            A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
            chk("busy_after_accept", busy, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int guard;
        logic [3:0] a2, b2;
        logic       bin2;

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_bout", Bout, 0);
        chk("rst_ovf", Overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd7, 4'd2, 1'b0);
        run_op(4'd2, 4'd7, 1'b0);
        run_op(4'b1000, 4'b0001, 1'b0);
        run_op(4'b0111, 4'b1000, 1'b0);

        // second start pulse lands mid-SHIFT and must be ignored
        run_op(4'd0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // reset abandons an in-flight operation without a done pulse
        wait_idle(ok);
        A = 4'd11; B = 4'd6; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_diff", Diff, 15);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_diff", Diff, 0);
        chk("midrst_bout", Bout, 0);
        chk("midrst_ovf", Overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_op(4'd5, 4'd3, 1'b0);

        // start held high: second acceptance exactly WIDTH+2 edges after the first
        wait_idle(ok);
        if (ok) begin
            a2 = 4'($urandom); b2 = 4'($urandom); bin2 = 1'($urandom);
            A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom); start = 1'b1;
            q.push_back(model(A, B, Bin, cyc + 1 + 4));
            q.push_back(model(a2, b2, bin2, cyc + 1 + 6 + 4));
            pushed += 2;
            @(posedge clk);
            #1;
            A = a2; B = b2; Bin = bin2;
            repeat (6) @(posedge clk);
            #1;
            start = 1'b0;
            chk("busy_b2b", busy, 1);
        end

        for (int i = 0; i < 512; i++) begin
            run_op(4'(i >> 5), 4'(i >> 1), 1'(i));
        end
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(4'($urandom), 4'($urandom), 1'($urandom));
        end

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", done_cnt, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
